// File: rtl/buffer_mux_pkg.sv
// Shared word layout, requester count and arbiter state encoding for the
// four-input buffer mux feeding the memory write path.
package buffer_mux_pkg;

    localparam int WORD_W    = 35;
    localparam int VALID_BIT = 34;
    localparam int LAST_BIT  = 33;
    localparam int NUM_REQ   = 4;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans four requests starting at ptr
// (wrapping 3 -> 0) and returns the first hit as a one-hot vector.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] pick,
    output logic       any
);

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        pick = 4'b0000;
        any  = |req;
        for (int i = 3; i >= 0; i--) begin
            logic [1:0] idx;
            idx = ptr + 2'(i);
            if (req[idx]) begin
                pick = 4'b0001 << idx;
            end
        end
    end

endmodule

// File: rtl/buffer_mux_arbiter.sv
// Packet-granular round-robin arbiter for the four-input buffer mux.
// Optional burst timeout is enabled by defining BUFFER_ARB_TIMEOUT_EN.
module buffer_mux_arbiter
    import buffer_mux_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                next_ready,
    input  logic                mem_full,
    input  logic [WORD_W-1:0]   in_data0,
    input  logic [WORD_W-1:0]   in_data1,
    input  logic [WORD_W-1:0]   in_data2,
    input  logic [WORD_W-1:0]   in_data3,
    output logic                ready0,
    output logic                ready1,
    output logic                ready2,
    output logic                ready3,
    output logic [WORD_W-1:0]   out_data,
    output logic [NUM_REQ-1:0]  grant,
    output logic                busy
);

    arb_state_e          state, state_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic [1:0]          ptr, ptr_d;
    logic [WORD_W-1:0]   out_d;
    logic [3:0]          valid_vec, ready_vec, pick;
    logic                pick_any, fire, timeout_hit;
    logic [WORD_W-1:0]   sel_word;
    logic [1:0]          gidx;

    assign valid_vec = {in_data3[VALID_BIT], in_data2[VALID_BIT],
                        in_data1[VALID_BIT], in_data0[VALID_BIT]};

    // Readies follow the registered grant, so they are zero in ARB for free.
    assign ready_vec = grant & {4{next_ready & ~mem_full}};
    assign ready0    = ready_vec[0];
    assign ready1    = ready_vec[1];
    assign ready2    = ready_vec[2];
    assign ready3    = ready_vec[3];
    assign fire      = |(ready_vec & valid_vec);
    assign busy      = (state == XFER);

    assign sel_word = ({WORD_W{grant[0]}} & in_data0) |
                      ({WORD_W{grant[1]}} & in_data1) |
                      ({WORD_W{grant[2]}} & in_data2) |
                      ({WORD_W{grant[3]}} & in_data3);

    always_comb begin
        gidx = 2'd0;
        if (grant[1]) gidx = 2'd1;
        if (grant[2]) gidx = 2'd2;
        if (grant[3]) gidx = 2'd3;
    end

    rr_pick4 u_pick (
        .req  (valid_vec),
        .ptr  (ptr),
        .pick (pick),
        .any  (pick_any)
    );

`ifdef BUFFER_ARB_TIMEOUT_EN
    logic [7:0] burst_cnt, cnt_d;
    assign timeout_hit = (burst_cnt == 8'(MAX_BURST - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state;
        grant_d = grant;
        ptr_d   = ptr;
        out_d   = '0;
`ifdef BUFFER_ARB_TIMEOUT_EN
        cnt_d   = burst_cnt;
`endif
        case (state)
            ARB: begin
                if (pick_any) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (fire) begin
                    out_d = sel_word;
                    // A forced release marks the word as last so the packet closes downstream.
                    if (sel_word[LAST_BIT] || timeout_hit) begin
                        out_d[LAST_BIT] = 1'b1;
                        grant_d         = '0;
                        ptr_d           = gidx + 2'd1;
                        state_d         = ARB;
`ifdef BUFFER_ARB_TIMEOUT_EN
                        cnt_d           = '0;
`endif
                    end else begin
`ifdef BUFFER_ARB_TIMEOUT_EN
                        if (burst_cnt != 8'(MAX_BURST)) begin
                            cnt_d = burst_cnt + 8'd1;
                        end
`endif
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB;
            grant    <= '0;
            ptr      <= 2'd0;
            out_data <= '0;
`ifdef BUFFER_ARB_TIMEOUT_EN
            burst_cnt <= '0;
`endif
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            ptr      <= ptr_d;
            out_data <= out_d;
`ifdef BUFFER_ARB_TIMEOUT_EN
            burst_cnt <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/buffer_mux_arbiter.md
# buffer_mux_arbiter

Round-robin arbiter and sequencer for the four-input buffer mux feeding the memory write path. Picks one of four 35-bit requester streams, holds the grant for a whole packet (until a word with the last flag), and drives per-requester ready handshakes gated by downstream `next_ready` and `mem_full`. Forwards the selected word through a single output register.

## Interface
- `NUM_REQ`, 4: requester count (fixed at 4; parameter documents intent)
- `MAX_BURST`, 16: words per grant before forced release (used only with `BUFFER_ARB_TIMEOUT_EN`); legal range 2..255
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset (asserts immediately, releases synchronously to `clk`)
- `next_ready` in 1: downstream can accept a word this cycle
- `mem_full` in 1: memory full; blocks all transfers
- `in_data0`..`in_data3` in 35 each: requester words; [34]=valid, [33]=last, [32:0]=payload
- `ready0`..`ready3` out 1 each: word on matching input is consumed this cycle
- `out_data` out 35: registered forwarded word; [34]=valid
- `grant` out 4: one-hot registered grant, 0 when idle
- `busy` out 1: high while a grant is held

## Operation
- States: `ARB` (no grant) and `XFER` (grant held). Reset state `ARB`.
- `ARB`: if any `in_dataK[34]` is set, pick the first valid requester scanning from `ptr` upward, modulo 4. Register `grant` one-hot and go to `XFER`. Otherwise stay in `ARB`.
- `ptr` is a 2-bit round-robin pointer, reset to 0.
- `XFER`: `readyK = grant[K] & next_ready & ~mem_full`, combinational. Non-granted readies are always 0. A transfer occurs when `readyK & in_dataK[34]`.
- On a transfer, `out_data <= in_dataK`. On a non-transfer cycle, `out_data <= 35'h0`, so valid is never duplicated.
- A transfer with [33]=1 ends the packet: `grant <= 0`, `ptr <= K+1` (wraps 3 to 0), `burst_cnt <= 0`, return to `ARB`.
- Granted requester drops valid mid-packet: grant is held and no transfer happens. There is no release without last (except on timeout).
- `mem_full=1` or `next_ready=0`: all readies are 0, and state, counter and grant are frozen.
- `burst_cnt` counts transfers in the current grant; it saturates at `MAX_BURST`.
- Simultaneous requests in `ARB`: only the pointer order decides. Requests arriving while in `XFER` wait.

## Timing
- Reset values: `ready0..3=0`, `out_data=0`, `grant=0`, `busy=0`, `ptr=0`, `burst_cnt=0`, state `ARB`.
- Arbitration latency: 1 cycle. A request seen in `ARB` at edge N gives `grant` valid after edge N, and the first ready can assert in that cycle.
- Data latency: 1 cycle. The word consumed in cycle C appears on `out_data` after edge C+1.
- Release bubble: after a last word there is exactly one `ARB` cycle with no ready asserted.
- Peak throughput per packet: 1 word/cycle.
- Reset asserted mid-packet: all outputs clear at once. The partial packet is abandoned, and the next grant after release goes to `ptr=0`.

## Configuration
- `BUFFER_ARB_TIMEOUT_EN` defined: when the `MAX_BURST`-th word of a grant transfers without a last flag, the arbiter sets `out_data[33]=1` on that word and releases exactly as for a real last word (`ptr` advances). This prevents a requester from hogging the grant.
- `BUFFER_ARB_TIMEOUT_EN` undefined: no timeout. `burst_cnt` and `MAX_BURST` are unused, and a grant lasts until a real last word.

## Structure
- Shared package `buffer_mux_pkg` holds:
  - `WORD_W=35`, `VALID_BIT=34`, `LAST_BIT=33`, `NUM_REQ=4`
  - state enum `{ARB, XFER}`
- Sub-module `rr_pick4`: combinational. Takes 4-bit request and 2-bit pointer; returns one-hot pick and `any`.
- Top level holds the FSM, counter, ready gating and output register.

## Test plan
- Reset with `in_data0=35'h400000000` held → all outputs 0. After release: `grant=4'b0001` after 1 edge; `ready0=1`; `out_data=35'h400000000` one edge later, then 0 once valid drops.
- All four valid with last set, `ptr=0` → grants in order 0,1,2,3,0, each separated by one `ARB` bubble.
- Requester 2 sends 3 words, the third `35'h6_0000_0003`. Assert `mem_full=1` for 2 cycles mid-packet → `ready2=0`, `out_data` valid=0 for those cycles. Packet completes, then `grant=0`.
- `next_ready=0` while granted, then requester drops valid for 3 cycles → grant held, no output words, no release.
- Reset asserted during the second of four words → immediate clear; next grant goes to requester 0 despite the prior pointer.
- With `BUFFER_ARB_TIMEOUT_EN` and `MAX_BURST=4`: requester 1 streams 6 words without last → 4th output word has bit 33=1, grant released, `ptr=2`.
